// File: rtl/adc_sar_ctrl_if.sv
// -----------------------------------------------------------------------------
// adc_sar_ctrl_if
// Signal bundle between the SAR sequencer and the rest of the system
// (register/CPU side plus the 4-channel analog ADC/DAC macro).
//
//   cfg_enable, cfg_ch_mask[3:0], cfg_continuous : configuration (to sequencer)
//   conv_req          : one-cycle sweep start pulse (to sequencer)
//   adc_result[3:0]   : raw comparator outputs, asynchronous (to sequencer)
//   dac_din0..3[7:0]  : DAC trial/final codes (from sequencer)
//   adc_sample[3:0]   : SAMPLE strobes, at most one bit high (from sequencer)
//   adc_sel[3:0]      : registered channel select (from sequencer)
//   busy, conv_done   : sweep status (from sequencer)
//   ch_data0..3[7:0], ch_valid[3:0] : latest codes and sticky valid flags
//   dbg_state[2:0]    : sequencer FSM state, for observation only
//
// master = sequencer view, slave = system/macro view.
// -----------------------------------------------------------------------------
interface adc_sar_ctrl_if;
  logic       cfg_enable;
  logic [3:0] cfg_ch_mask;
  logic       cfg_continuous;
  logic       conv_req;
  logic [3:0] adc_result;
  logic [7:0] dac_din0;
  logic [7:0] dac_din1;
  logic [7:0] dac_din2;
  logic [7:0] dac_din3;
  logic [3:0] adc_sample;
  logic [3:0] adc_sel;
  logic       busy;
  logic [7:0] ch_data0;
  logic [7:0] ch_data1;
  logic [7:0] ch_data2;
  logic [7:0] ch_data3;
  logic [3:0] ch_valid;
  logic       conv_done;
  logic [2:0] dbg_state;

  modport master (
    input  cfg_enable, cfg_ch_mask, cfg_continuous, conv_req, adc_result,
    output dac_din0, dac_din1, dac_din2, dac_din3, adc_sample, adc_sel, busy,
           ch_data0, ch_data1, ch_data2, ch_data3, ch_valid, conv_done, dbg_state
  );

  modport slave (
    output cfg_enable, cfg_ch_mask, cfg_continuous, conv_req, adc_result,
    input  dac_din0, dac_din1, dac_din2, dac_din3, adc_sample, adc_sel, busy,
           ch_data0, ch_data1, ch_data2, ch_data3, ch_valid, conv_done, dbg_state
  );
endinterface

// File: rtl/adc_sar_ctrl.sv
// -----------------------------------------------------------------------------
// adc_sar_ctrl
// Successive-approximation sequencer for the 4-channel ADC/DAC macro. Each
// channel's DAC is the SAR reference: trial codes go out on dac_dinN, SAMPLE
// is pulsed, and the synchronized comparator output decides each bit, MSB
// first. Enabled channels are swept in ascending order, single-shot or
// back-to-back, and the last finished code per channel is held in ch_dataN.
//
// Ports:
//   mclk  : block clock
//   reset : synchronous, active-high reset
//   bus   : adc_sar_ctrl_if.master (configuration, conv_req, comparator in,
//           DAC codes, SAMPLE/SEL strobes, status, results, FSM debug state)
//
// Handshake: conv_req is a single-cycle start pulse honoured only in IDLE with
// cfg_enable high and a non-zero mask; busy is high from the first cycle after
// acceptance until the FSM is back in IDLE; conv_done is a one-cycle pulse in
// the DONE state. There is no back-pressure.
//
// Parameters: SETTLE_CYC (Din hold before SAMPLE, >=1), SAMPLE_CYC (SAMPLE
// width, >=1). Per bit: SETTLE_CYC + SAMPLE_CYC + 2 sync + 1 decide cycles.
//
// Optional build macro ADC_SAR_AVG_EN: each channel is converted four times
// and ch_data is the truncated mean (10-bit sum >> 2).
// -----------------------------------------------------------------------------
module adc_sar_ctrl #(
  parameter int SETTLE_CYC = 4,
  parameter int SAMPLE_CYC = 2
) (
  input  logic           mclk,
  input  logic           reset,
  adc_sar_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_SAMPLE, S_SYNC, S_DECIDE, S_DONE
  } state_e;

  localparam int CNT_MAX0 = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
  localparam int CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYC - 1);
  localparam logic [CW-1:0] SYNC_LAST   = CW'(1);

  state_e          state_q, state_d;
  logic [1:0]      ch_q, ch_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0]      serviced_q, serviced_d;
  logic [7:0]      bit_q, bit_d;
  logic [7:0]      code_q, code_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0][7:0] dac_q, dac_d;
  logic [3:0][7:0] data_q, data_d;
  logic [3:0]      valid_q, valid_d;
  logic [3:0]      sel_q;
  logic [3:0]      sync1_q, sync2_q;
`ifdef ADC_SAR_AVG_EN
  logic [1:0]      rep_q, rep_d;
  logic [9:0]      sum_q, sum_d;
  logic [9:0]      sum_n;
`endif

  logic [3:0] pending;
  logic [1:0] pick;
  logic [7:0] code_n;
  logic [7:0] bit_n;

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      mask_q     <= '0;
      serviced_q <= '0;
      bit_q      <= '0;
      code_q     <= '0;
      cnt_q      <= '0;
      dac_q      <= '0;
      data_q     <= '0;
      valid_q    <= '0;
      sel_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
`ifdef ADC_SAR_AVG_EN
      rep_q      <= '0;
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      mask_q     <= mask_d;
      serviced_q <= serviced_d;
      bit_q      <= bit_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      dac_q      <= dac_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sel_q      <= bus.cfg_ch_mask & {4{bus.cfg_enable}};
      // Comparator outputs are asynchronous; only sync2_q is ever decoded.
      sync1_q    <= bus.adc_result;
      sync2_q    <= sync1_q;
`ifdef ADC_SAR_AVG_EN
      rep_q      <= rep_d;
      sum_q      <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    mask_d     = mask_q;
    serviced_d = serviced_q;
    bit_d      = bit_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    dac_d      = dac_q;
    data_d     = data_q;
    valid_d    = valid_q;
`ifdef ADC_SAR_AVG_EN
    rep_d      = rep_q;
    sum_d      = sum_q;
`endif

    // Lowest-numbered masked channel not yet serviced in this sweep.
    pending = mask_q & ~serviced_q;
    pick    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) pick = 2'(i);
    end

    code_n = sync2_q[ch_q] ? (code_q | bit_q) : code_q;
    bit_n  = bit_q >> 1;
`ifdef ADC_SAR_AVG_EN
    sum_n  = sum_q + {2'b00, code_n};
`endif

    // Dropping enable abandons the sweep without touching results.
    if (!bus.cfg_enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.conv_req && (bus.cfg_ch_mask != 4'd0)) begin
            mask_d     = bus.cfg_ch_mask;
            serviced_d = '0;
            valid_d    = '0;
`ifdef ADC_SAR_AVG_EN
            rep_d      = '0;
            sum_d      = '0;
`endif
            state_d    = S_SELECT;
          end
        end
        S_SELECT: begin
          if (pending == 4'd0) begin
            state_d = S_DONE;
          end else begin
            ch_d        = pick;
            bit_d       = 8'h80;
            code_d      = 8'h00;
            dac_d[pick] = 8'h80;
            cnt_d       = '0;
            state_d     = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SAMPLE: begin
          if (cnt_q == SAMPLE_LAST) begin
            cnt_d   = '0;
            state_d = S_SYNC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SYNC: begin
          if (cnt_q == SYNC_LAST) begin
            cnt_d   = '0;
            state_d = S_DECIDE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DECIDE: begin
          if (bit_q != 8'h01) begin
            code_d      = code_n;
            bit_d       = bit_n;
            dac_d[ch_q] = code_n | bit_n;
            cnt_d       = '0;
            state_d     = S_SETTLE;
          end else begin
            // The DAC is left parked on the final code of this conversion.
            dac_d[ch_q] = code_n;
`ifdef ADC_SAR_AVG_EN
            if (rep_q == 2'd3) begin
              data_d[ch_q]     = sum_n[9:2];
              valid_d[ch_q]    = 1'b1;
              serviced_d[ch_q] = 1'b1;
              rep_d            = '0;
              sum_d            = '0;
            end else begin
              // Not serviced yet, so SELECT restarts the same channel.
              rep_d = rep_q + 2'd1;
              sum_d = sum_n;
            end
`else
            data_d[ch_q]     = code_n;
            valid_d[ch_q]    = 1'b1;
            serviced_d[ch_q] = 1'b1;
`endif
            state_d = S_SELECT;
          end
        end
        S_DONE: begin
          if (bus.cfg_continuous) begin
            mask_d     = bus.cfg_ch_mask;
            serviced_d = '0;
            valid_d    = '0;
            state_d    = S_SELECT;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.dac_din0   = dac_q[0];
  assign bus.dac_din1   = dac_q[1];
  assign bus.dac_din2   = dac_q[2];
  assign bus.dac_din3   = dac_q[3];
  assign bus.ch_data0   = data_q[0];
  assign bus.ch_data1   = data_q[1];
  assign bus.ch_data2   = data_q[2];
  assign bus.ch_data3   = data_q[3];
  assign bus.ch_valid   = valid_q;
  assign bus.adc_sel    = sel_q;
  assign bus.adc_sample = (state_q == S_SAMPLE) ? (4'b0001 << ch_q) : 4'b0000;
  assign bus.busy       = (state_q != S_IDLE);
  // A sweep aborted by enable in DONE must not report completion.
  assign bus.conv_done  = (state_q == S_DONE) && bus.cfg_enable;
  assign bus.dbg_state  = state_q;

endmodule
